alu_arbiter: RTL



---
 rtl/alu_pkg.sv | 28 ++
 rtl/Arithmetic.sv | 42 ++++
 rtl/alu_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode constants, arbiter state encoding and the latched-request struct.
// No timing of its own.
// No flow control of its own.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_INC = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_DEC = 4'b0111;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_EXEC = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [3:0] op;
        logic [3:0] a;
        logic [3:0] b;
    } alu_req_t;

    // The four legal opcodes share the 4'b01xx prefix.
    function automatic logic op_legal(input logic [3:0] op);
        return op[3:2] == 2'b01;
    endfunction

endpackage

// File: rtl/Arithmetic.sv
// 4-bit ADD/INC/SUB/DEC datapath with raw carry-out and signed overflow.
// Latency: combinational.
// Backpressure: none; the caller holds the operands steady.
module Arithmetic
    import alu_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] op,
    output logic [3:0] arith_out,
    output logic       c,
    output logic       v
);

    logic [3:0] y;
    logic       cin;
    logic       en;
    logic [4:0] sum;

    // Every operation is a + y + cin; only y and cin depend on the opcode.
    always_comb begin
        y   = 4'b0000;
        cin = 1'b0;
        en  = 1'b1;
        case (op)
            OP_ADD: y = b;
            OP_INC: cin = 1'b1;
            OP_SUB: begin
                y   = ~b;
                cin = 1'b1;
            end
            OP_DEC: y = 4'b1111;
            default: en = 1'b0;
        endcase
    end

    assign sum       = {1'b0, a} + {1'b0, y} + {4'b0000, cin};
    assign arith_out = en ? sum[3:0] : 4'b0000;
    assign c         = en & sum[4];
    assign v         = en & (a[3] == y[3]) & (sum[3] != a[3]);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one Arithmetic unit between two requesters; ALU_ARB_OPCHK_EN adds rsp_err.
// Latency: response valid 2 cycles after the accept cycle (1 for a rejected opcode with ALU_ARB_OPCHK_EN).
// Backpressure: one op in flight; req_ready low until rsp_ready of the granted requester drains RESP.
module alu_arbiter
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_valid,
    output logic [1:0] req_ready,
    input  logic [3:0] req_a0,
    input  logic [3:0] req_a1,
    input  logic [3:0] req_b0,
    input  logic [3:0] req_b1,
    input  logic [3:0] req_op0,
    input  logic [3:0] req_op1,
    output logic [1:0] rsp_valid,
    input  logic [1:0] rsp_ready,
    output logic [3:0] rsp_result,
    output logic       rsp_c,
    output logic       rsp_v,
    output logic       rsp_err
);

    arb_state_t state;
    logic       prio;
    logic       gnt;
    alu_req_t   opnd;
    logic       sel;
    alu_req_t   sel_req;
    logic       xfer;
    logic [3:0] arith_out;
    logic       arith_c;
    logic       arith_v;

    // With both requesters valid the pointer decides; otherwise whoever is valid.
    always_comb begin
        sel       = (&req_valid) ? prio : req_valid[1];
        sel_req   = sel ? '{op: req_op1, a: req_a1, b: req_b1}
                        : '{op: req_op0, a: req_a0, b: req_b0};
        req_ready = 2'b00;
        if (state == ARB_IDLE && |req_valid) begin
            req_ready[sel] = 1'b1;
        end
    end

    assign xfer = |(req_valid & req_ready);

    Arithmetic u_arith (
        .a         (opnd.a),
        .b         (opnd.b),
        .op        (opnd.op),
        .arith_out (arith_out),
        .c         (arith_c),
        .v         (arith_v)
    );

`ifdef ALU_ARB_OPCHK_EN
    logic err_q;
    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB_IDLE;
            prio       <= 1'b0;
            gnt        <= 1'b0;
            opnd       <= '0;
            rsp_valid  <= 2'b00;
            rsp_result <= 4'b0000;
            rsp_c      <= 1'b0;
            rsp_v      <= 1'b0;
`ifdef ALU_ARB_OPCHK_EN
            err_q      <= 1'b0;
`endif
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (xfer) begin
                        opnd  <= sel_req;
                        gnt   <= sel;
                        state <= ARB_EXEC;
`ifdef ALU_ARB_OPCHK_EN
                        // Bad opcodes bypass the datapath and answer with an error.
                        if (!op_legal(sel_req.op)) begin
                            state      <= ARB_RESP;
                            rsp_valid  <= sel ? 2'b10 : 2'b01;
                            rsp_result <= 4'b0000;
                            rsp_c      <= 1'b0;
                            rsp_v      <= 1'b0;
                            err_q      <= 1'b1;
                        end
`endif
                    end
                end
                ARB_EXEC: begin
                    rsp_result <= arith_out;
                    rsp_c      <= arith_c;
                    rsp_v      <= arith_v;
                    rsp_valid  <= gnt ? 2'b10 : 2'b01;
                    state      <= ARB_RESP;
`ifdef ALU_ARB_OPCHK_EN
                    err_q      <= 1'b0;
`endif
                end
                ARB_RESP: begin
                    if (rsp_ready[gnt]) begin
                        rsp_valid <= 2'b00;
                        prio      <= ~gnt;
                        state     <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule
